// File: rtl/reg_share_arb.sv
// Shared W-bit register loaded by N requesters through a round-robin arbiter.
// Optional macro REG_SHARE_ARB_LOCK_EN adds a lock input that lets one requester hold the slot.
module reg_share_arb #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
`ifdef REG_SHARE_ARB_LOCK_EN
    input  logic [N-1:0]         lock,
`endif
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic                 q_valid,
    output logic [$clog2(N)-1:0] q_src,
    input  logic                 q_ready,
    output logic [1:0]           dbg_state_o
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  q_q;
    logic [SW-1:0] src_q;
    logic [SW-1:0] ptr_q;

    logic          slot_free;
    logic          any_hit;
    logic          grant_en;
    logic [SW-1:0] idx;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] nxt_idx;
    logic [W-1:0]  din_a [N];

    if (N < 2 || N > 8 || LOCK_MAX < 1 || LOCK_MAX > 15) begin : g_param_check
        $error("reg_share_arb: parameter out of range");
    end

    // Valid/ready: the slot accepts a new entry when it is empty or being consumed this edge.
    always_comb begin
        slot_free = (state_q == EMPTY) || q_ready;
        any_hit   = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            din_a[k] = din[k*W +: W];
            idx = SW'((int'(ptr_q) + k) % N);
            if (!any_hit && req[idx]) begin
                any_hit = 1'b1;
                gnt_idx = idx;
            end
        end
        grant_en = rst_n && slot_free && any_hit;
        nxt_idx  = SW'((int'(gnt_idx) + 1) % N);
        gnt      = '0;
        if (grant_en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

`ifdef REG_SHARE_ARB_LOCK_EN
    logic [3:0] cnt_q;
    logic [3:0] base_cnt;
    logic       lock_hold;

    // A lock run only continues for the requester the pointer is parked on.
    always_comb begin
        base_cnt  = (state_q == LOCKED && gnt_idx == ptr_q) ? cnt_q : 4'd0;
        lock_hold = lock[gnt_idx] && ((int'(base_cnt) + 1) < LOCK_MAX);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            q_q     <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
`ifdef REG_SHARE_ARB_LOCK_EN
            cnt_q   <= '0;
`endif
        end else if (grant_en) begin
            q_q   <= din_a[gnt_idx];
            src_q <= gnt_idx;
`ifdef REG_SHARE_ARB_LOCK_EN
            if (lock_hold) begin
                ptr_q   <= gnt_idx;
                cnt_q   <= base_cnt + 4'd1;
                state_q <= LOCKED;
            end else begin
                ptr_q   <= nxt_idx;
                cnt_q   <= '0;
                state_q <= FULL;
            end
`else
            ptr_q   <= nxt_idx;
            state_q <= FULL;
`endif
        end else if (state_q != EMPTY && q_ready) begin
            state_q <= EMPTY;
`ifdef REG_SHARE_ARB_LOCK_EN
            // Locked requester withdrew while the slot was free: release the lock.
            if (state_q == LOCKED) begin
                ptr_q <= SW'((int'(ptr_q) + 1) % N);
                cnt_q <= '0;
            end
`endif
        end
    end

    assign q           = q_q;
    assign q_src       = src_q;
    assign q_valid     = (state_q != EMPTY);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Self-checking bench for reg_share_arb: directed scenarios plus randomized traffic
// compared against a queue-based round-robin reference model.
module tb_reg_share_arb;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] din = '0;
    logic [N-1:0] gnt;
    logic [W-1:0] q;
    logic         q_valid;
    logic [1:0]   q_src;
    logic         q_ready = 1'b0;
    logic [1:0]   dbg_state;
`ifdef REG_SHARE_ARB_LOCK_EN
    logic [N-1:0] lock = '0;
`endif

    int errors = 0;
    int checks = 0;

    reg_share_arb #(.N(N), .W(W), .LOCK_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
`ifdef REG_SHARE_ARB_LOCK_EN
        .lock       (lock),
`endif
        .gnt        (gnt),
        .q          (q),
        .q_valid    (q_valid),
        .q_src      (q_src),
        .q_ready    (q_ready),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference arbitration: walk requesters in rotated order from the pointer.
    function automatic int ref_grant(input logic [N-1:0] r, input int p);
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((p + k) % N);
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt_in_reset got=%b exp=0000", gnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || q_valid !== 1'b0 || q !== 8'h00 || q_src !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got gnt=%b qv=%b q=%h src=%0d exp 0000/0/00/0", c, gnt, q_valid, q, q_src);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        din     = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req     = 4'b1111;
        q_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", i, gnt, 4'(1 << (i % 4))); end
            @(posedge clk);
            #1;
            checks++;
            if (q !== 8'(8'hA0 + (i % 4)) || q_src !== 2'(i % 4) || q_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_q step=%0d got q=%h src=%0d qv=%b exp q=%h src=%0d qv=1", i, q, q_src, q_valid, 8'(8'hA0 + (i % 4)), i % 4);
            end
        end
    endtask

    task automatic test_stall_consume();
        do_reset();
        din     = {8'h00, 8'h5C, 8'h00, 8'h00};
        req     = 4'b0100;
        q_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL stall_first_gnt got=%b exp=0100", gnt); end
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'b0000 || q !== 8'h5C || q_valid !== 1'b1 || q_src !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got gnt=%b q=%h qv=%b src=%0d exp 0000/5c/1/2", c, gnt, q, q_valid, q_src);
            end
        end
        req     = '0;
        q_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL consume_gnt got=%b exp=0000", gnt); end
        @(posedge clk);
        #1;
        checks++;
        if (q_valid !== 1'b0 || q !== 8'h5C || q_src !== 2'd2) begin
            errors++;
            $display("FAIL consume_state got qv=%b q=%h src=%0d exp 0/5c/2", q_valid, q, q_src);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        din     = {8'h00, 8'h00, 8'h22, 8'h11};
        req     = 4'b0001;
        q_ready = 1'b0;
        @(posedge clk);
        #1;
        req     = 4'b0010;
        q_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_gnt got=%b exp=0010", gnt); end
        @(posedge clk);
        #1;
        checks++;
        if (q_valid !== 1'b1 || q !== 8'h22 || q_src !== 2'd1) begin
            errors++;
            $display("FAIL b2b_load got qv=%b q=%h src=%0d exp 1/22/1", q_valid, q, q_src);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        din     = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        req     = 4'b1111;
        q_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (q_valid !== 1'b1 || q !== 8'hD0) begin errors++; $display("FAIL midrst_pre got qv=%b q=%h exp 1/d0", q_valid, q); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL midrst_gnt got=%b exp=0000", gnt); end
        @(posedge clk);
        #1;
        checks++;
        if (q_valid !== 1'b0 || q !== 8'h00 || q_src !== 2'd0) begin
            errors++;
            $display("FAIL midrst_clear got qv=%b q=%h src=%0d exp 0/00/0", q_valid, q, q_src);
        end
        rst_n   = 1'b1;
        q_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL midrst_first_gnt got=%b exp=0001", gnt); end
        @(posedge clk);
        #1;
        req = '0;
    endtask

`ifdef REG_SHARE_ARB_LOCK_EN
    task automatic test_lock();
        int exp_seq[6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        din     = {8'h00, 8'h00, 8'hB1, 8'hB0};
        req     = 4'b0011;
        lock    = 4'b0001;
        q_ready = 1'b1;
        foreach (exp_seq[i]) begin
            @(negedge clk);
            checks++;
            if (gnt !== 4'(1 << exp_seq[i])) begin errors++; $display("FAIL lock_gnt step=%0d got=%b exp=%b", i, gnt, 4'(1 << exp_seq[i])); end
            @(posedge clk);
            #1;
        end
        lock = '0;
        req  = '0;
    endtask
`endif

    task automatic test_random();
        int       m_ptr = 0;
        logic     m_v   = 1'b0;
        logic [7:0] m_q = 8'h00;
        int       m_src = 0;
        int       exp_g;
        logic [N-1:0] exp_gnt;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(0, 39) != 0);
            req     = 4'($urandom_range(0, 15));
            din     = $urandom;
            q_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_g   = (rst_n && (!m_v || q_ready)) ? ref_grant(req, m_ptr) : -1;
            exp_gnt = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
            checks++;
            if (gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
            checks++;
            if (q_valid !== m_v || q !== m_q || q_src !== 2'(m_src)) begin
                errors++;
                $display("FAIL rand_q cyc=%0d got qv=%b q=%h src=%0d exp qv=%b q=%h src=%0d", c, q_valid, q, q_src, m_v, m_q, m_src);
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_ptr = 0; m_v = 1'b0; m_q = 8'h00; m_src = 0;
            end else if (exp_g >= 0) begin
                m_q   = din[exp_g*W +: W];
                m_src = exp_g;
                m_v   = 1'b1;
                m_ptr = (exp_g + 1) % N;
            end else if (m_v && q_ready) begin
                m_v = 1'b0;
            end
        end
        rst_n = 1'b1;
        req   = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall_consume();
        test_back_to_back();
        test_reset_mid();
`ifdef REG_SHARE_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
